// File: rtl/reversalmb_responder.sv
// -----------------------------------------------------------------------------
// reversalmb_responder
//
// Remote-side responder for the MBINIT REVERSALMB sideband handshake. It answers
// the partner's init / clear_error / result / done requests with the matching
// response code. Between clear_error_req and result_req it counts per-lane
// Lane-ID pattern matches. result_resp carries a per-lane pass vector.
//
// Optional feature macro: REVERSALMB_RESP_TIMEOUT_EN
//   When it is defined, a watchdog runs while waiting for a request. It raises a
//   one-cycle training error and returns the block to IDLE after TIMEOUT_CYCLES
//   idle cycles. When it is undefined, the block waits indefinitely and the
//   error output is tied low.
//
// Ports
//   CLK                               sole clock
//   rst                               synchronous, active-high reset
//   i_REPAIRVAL_end                   block enable; low forces IDLE
//   i_Rx_SbMessage / i_msg_valid      decoded RX sideband request + strobe
//   i_Busy_SideBand                   sideband TX busy
//   i_falling_edge_busy               TX finished the current message (strobe)
//   i_Lane_Match_valid / i_Lane_Match per-lane pattern comparison result
//   o_LaneID_Compare_En               enables the RX pattern comparator
//   o_TX_SbMessage / o_ValidOutDatat_Module  response code + valid toward TX
//   o_REVERSAL_Result                 per-lane pass vector (result_resp data)
//   o_REVERSALMB_Resp_end             high while in DONE
//   o_train_error_req_reversalmb_resp request-wait timeout pulse
// -----------------------------------------------------------------------------
//
// state        | meaning
// -------------+---------------------------------------------------------------
// S_IDLE       | block disabled or just reset; nothing in flight
// S_WAIT_REQ   | listening for an odd request code (1/3/5/7)
// S_CHECK_BUSY | response latched, waiting for sideband TX to go idle
// S_SEND_RESP  | response driven with valid until TX reports completion
// S_DONE       | done_resp sent; handshake complete until enable drops
module reversalmb_responder #(
  parameter int NUM_LANES      = 16,
  parameter int CNT_W          = 4,
  parameter int PASS_THRESH    = 8,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 i_REPAIRVAL_end,
  input  logic [3:0]           i_Rx_SbMessage,
  input  logic                 i_msg_valid,
  input  logic                 i_Busy_SideBand,
  input  logic                 i_falling_edge_busy,
  input  logic                 i_Lane_Match_valid,
  input  logic [NUM_LANES-1:0] i_Lane_Match,
  output logic                 o_LaneID_Compare_En,
  output logic [3:0]           o_TX_SbMessage,
  output logic                 o_ValidOutDatat_Module,
  output logic [NUM_LANES-1:0] o_REVERSAL_Result,
  output logic                 o_REVERSALMB_Resp_end,
  output logic                 o_train_error_req_reversalmb_resp
);

  if (PASS_THRESH < 1 || PASS_THRESH > (2**CNT_W) - 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("reversalmb_responder: PASS_THRESH or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_CHECK_BUSY,
    S_SEND_RESP,
    S_DONE
  } state_e;

  localparam logic [3:0]       MSG_CLEAR_ERROR_REQ = 4'd3;
  localparam logic [3:0]       MSG_RESULT_REQ      = 4'd5;
  localparam logic [3:0]       MSG_DONE_RESP       = 4'd8;
  localparam logic [CNT_W-1:0] CNT_MAX             = '1;
  localparam logic [CNT_W-1:0] THRESH              = CNT_W'(PASS_THRESH);

  state_e               state_q, state_d;
  logic [3:0]           resp_q, resp_d;
  logic                 cmp_en_q, cmp_en_d;
  logic [CNT_W-1:0]     cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d [NUM_LANES];
  logic [NUM_LANES-1:0] result_q, result_d;
  logic                 valid_q, valid_d;
  logic [3:0]           tx_q, tx_d;
  logic                 end_q, end_d;
  logic                 req_hit;

`ifdef REVERSALMB_RESP_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Only the four request codes 1/3/5/7 are answered; odd codes 9..15 are not.
  assign req_hit = i_msg_valid && !i_Rx_SbMessage[3] && i_Rx_SbMessage[0];

  always_comb begin
    state_d  = state_q;
    resp_d   = resp_q;
    cmp_en_d = cmp_en_q;
    result_d = result_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cmp_en_q && i_Lane_Match_valid && i_Lane_Match[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
`ifdef REVERSALMB_RESP_TIMEOUT_EN
    tmo_d = '0;
    err_d = 1'b0;
`endif

    if (!i_REPAIRVAL_end) begin
      state_d  = S_IDLE;
      cmp_en_d = 1'b0;
      result_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT_REQ;

        S_WAIT_REQ: begin
          if (req_hit) begin
            resp_d  = i_Rx_SbMessage + 4'd1;
            state_d = S_CHECK_BUSY;
            if (i_Rx_SbMessage == MSG_CLEAR_ERROR_REQ) begin
              // A retry restarts counting; zeroing wins over a coincident strobe.
              cmp_en_d = 1'b1;
              result_d = '0;
              for (int i = 0; i < NUM_LANES; i++) begin
                cnt_d[i] = '0;
              end
            end else if (i_Rx_SbMessage == MSG_RESULT_REQ) begin
              // Snapshot pre-edge counts so a strobe in this cycle is excluded.
              cmp_en_d = 1'b0;
              for (int i = 0; i < NUM_LANES; i++) begin
                result_d[i] = (cnt_q[i] >= THRESH);
                cnt_d[i]    = cnt_q[i];
              end
            end
          end
`ifdef REVERSALMB_RESP_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            cmp_en_d = 1'b0;
            result_d = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
              cnt_d[i] = '0;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end

        S_CHECK_BUSY: begin
          if (!i_Busy_SideBand) begin
            state_d = S_SEND_RESP;
          end
        end

        S_SEND_RESP: begin
          if (i_falling_edge_busy) begin
            state_d = (resp_q == MSG_DONE_RESP) ? S_DONE : S_WAIT_REQ;
          end
        end

        S_DONE: begin
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they align with the state.
    valid_d = (state_d == S_SEND_RESP);
    tx_d    = valid_d ? resp_d : 4'd0;
    end_d   = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      resp_q   <= '0;
      cmp_en_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      tx_q     <= '0;
      end_q    <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef REVERSALMB_RESP_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      cmp_en_q <= cmp_en_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      tx_q     <= tx_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
`ifdef REVERSALMB_RESP_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign o_LaneID_Compare_En    = cmp_en_q;
  assign o_TX_SbMessage         = tx_q;
  assign o_ValidOutDatat_Module = valid_q;
  assign o_REVERSAL_Result      = result_q;
  assign o_REVERSALMB_Resp_end  = end_q;

`ifdef REVERSALMB_RESP_TIMEOUT_EN
  assign o_train_error_req_reversalmb_resp = err_q;
`else
  assign o_train_error_req_reversalmb_resp = 1'b0;
`endif

endmodule

// File: tb/tb_reversalmb_responder.sv
module tb_reversalmb_responder;
  logic        clk = 1'b0;
  logic        rst, en, msg_valid, busy, fall, mvalid;
  logic [3:0]  rxmsg;
  logic [15:0] match;
  logic        cmp_en, valid, resp_end, err;
  logic [3:0]  tx;
  logic [15:0] result;

  reversalmb_responder #(
    .NUM_LANES(16), .CNT_W(4), .PASS_THRESH(8), .TIMEOUT_CYCLES(8000)
  ) dut (
    .CLK                               (clk),
    .rst                               (rst),
    .i_REPAIRVAL_end                   (en),
    .i_Rx_SbMessage                    (rxmsg),
    .i_msg_valid                       (msg_valid),
    .i_Busy_SideBand                   (busy),
    .i_falling_edge_busy               (fall),
    .i_Lane_Match_valid                (mvalid),
    .i_Lane_Match                      (match),
    .o_LaneID_Compare_En               (cmp_en),
    .o_TX_SbMessage                    (tx),
    .o_ValidOutDatat_Module            (valid),
    .o_REVERSAL_Result                 (result),
    .o_REVERSALMB_Resp_end             (resp_end),
    .o_train_error_req_reversalmb_resp (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: match counts per lane, comparator enable, reported vector.
  int          mcnt [16];
  logic        m_en;
  logic [15:0] m_res;

  logic [3:0] ign [8] = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd9, 4'd11, 4'd15};

  typedef struct {
    int          n;
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
  endtask

  task automatic model_count(input logic [15:0] mask);
    if (m_en) begin
      for (int i = 0; i < 16; i++) begin
        if (mask[i]) mcnt[i] = (mcnt[i] >= 15) ? 15 : mcnt[i] + 1;
      end
    end
  endtask

  task automatic model_result();
    for (int i = 0; i < 16; i++) m_res[i] = (mcnt[i] >= 8);
  endtask

  task automatic model_clear_all();
    model_zero();
    m_en  = 1'b0;
    m_res = '0;
  endtask

  task automatic strobe(input logic [15:0] mask);
    mvalid = 1'b1;
    match  = mask;
    tick();
    mvalid = 1'b0;
    match  = '0;
    model_count(mask);
  endtask

  // Full handshake from WAIT_REQ: request (optionally with a coincident match
  // strobe), busy_cyc busy cycles, valid held hold_cyc extra cycles, completion.
  task automatic request(input logic [3:0] code, input int busy_cyc, input int hold_cyc,
                         input logic [15:0] smask);
    rxmsg     = code;
    msg_valid = 1'b1;
    mvalid    = (smask != 16'h0);
    match     = smask;
    tick();
    msg_valid = 1'b0;
    rxmsg     = '0;
    mvalid    = 1'b0;
    match     = '0;
    if (code == 4'd3) begin
      model_zero();
      m_en  = 1'b1;
      m_res = '0;
    end else if (code == 4'd5) begin
      model_result();
      m_en = 1'b0;
    end else begin
      model_count(smask);
    end
    check("cmp_en_after_req", cmp_en, m_en);
    check("valid_in_check_busy", valid, 0);
    for (int i = 0; i < busy_cyc; i++) begin
      busy = 1'b1;
      tick();
      check("valid_while_busy", valid, 0);
    end
    busy = 1'b0;
    tick();
    check("valid_rise", valid, 1);
    check("tx_code", tx, code + 1);
    for (int i = 0; i < hold_cyc; i++) begin
      tick();
      check("valid_hold", valid, 1);
    end
    fall = 1'b1;
    tick();
    fall = 1'b0;
    check("valid_fall", valid, 0);
    check("resp_end", resp_end, code == 4'd7);
    check("result", result, m_res);
    check("train_error", err, 0);
  endtask

  task automatic reset_mid_send();
    rxmsg     = 4'd1;
    msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    rxmsg     = '0;
    busy      = 1'b0;
    tick();
    check("pre_rst_valid", valid, 1);
    check("pre_rst_tx", tx, 2);
    rst = 1'b1;
    tick();
    model_clear_all();
    check("rst_valid", valid, 0);
    check("rst_tx", tx, 0);
    check("rst_cmp_en", cmp_en, 0);
    check("rst_result", result, 0);
    check("rst_end", resp_end, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; msg_valid = 1'b0; rxmsg = '0; busy = 1'b0;
    fall = 1'b0; mvalid = 1'b0; match = '0;
    model_clear_all();
    vecs[0] = '{10, 16'h00FF, 16'h00FF};
    vecs[1] = '{7,  16'h00FF, 16'h0000};
    vecs[2] = '{20, 16'h0001, 16'h0001};
    vecs[3] = '{8,  16'hA5A5, 16'hA5A5};
    vecs[4] = '{15, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{0,  16'hFFFF, 16'h0000};

    tick();
    tick();
    check("reset_cmp_en", cmp_en, 0);
    check("reset_tx", tx, 0);
    check("reset_valid", valid, 0);
    check("reset_result", result, 0);
    check("reset_end", resp_end, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // result_req without a preceding clear reports all-fail
    request(4'd5, 0, 0, 16'h0);
    check("result_no_clear", result, 16'h0000);
    request(4'd1, 0, 2, 16'h0);

    // Even codes and odd codes above 7 are ignored; state stays in WAIT_REQ
    for (int k = 0; k < 8; k++) begin
      rxmsg     = ign[k];
      msg_valid = 1'b1;
      tick();
      msg_valid = 1'b0;
      check("ignored_code_valid", valid, 0);
      check("ignored_code_cmp", cmp_en, 0);
    end
    rxmsg = '0;
    tick();
    check("ignored_code_tail", valid, 0);
    request(4'd1, 3, 0, 16'h0);

    // Table-driven count/threshold cases
    for (int k = 0; k < 6; k++) begin
      request(4'd3, 0, 0, 16'h0);
      for (int j = 0; j < vecs[k].n; j++) strobe(vecs[k].mask);
      request(4'd5, 0, 1, 16'h0);
      check("table_result", result, vecs[k].exp);
    end

    // Strobe coincident with result_req is not counted (7 -> would be 8)
    request(4'd3, 0, 0, 16'h0);
    for (int j = 0; j < 7; j++) strobe(16'hFFFF);
    request(4'd5, 0, 0, 16'hFFFF);
    check("result_strobe_excluded", result, 16'h0000);

    // Retry: second clear restarts counting, coincident strobe discarded
    request(4'd3, 1, 0, 16'h0);
    for (int j = 0; j < 10; j++) strobe(16'hF0F0);
    request(4'd3, 0, 0, 16'h0F0F);
    for (int j = 0; j < 3; j++) strobe(16'hFFFF);
    request(4'd5, 0, 0, 16'h0);
    check("retry_result", result, 16'h0000);

    // Match flags without the valid qualifier are ignored
    request(4'd3, 0, 0, 16'h0);
    for (int j = 0; j < 8; j++) begin
      match = 16'hFFFF;
      tick();
    end
    match = '0;
    for (int j = 0; j < 8; j++) strobe(16'h8001);
    request(4'd5, 0, 0, 16'h0);
    check("unqualified_match", result, 16'h8001);

    // Busy held five cycles delays valid
    request(4'd1, 5, 1, 16'h0);

    // A request during SEND_RESP is dropped
    rxmsg = 4'd1; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    tick();
    check("drop_send_valid", valid, 1);
    rxmsg = 4'd3; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0; rxmsg = '0;
    check("drop_send_cmp", cmp_en, 0);
    fall = 1'b1;
    tick();
    fall = 1'b0;
    check("drop_send_fall", valid, 0);
    tick();
    tick();
    check("drop_send_no_resp", valid, 0);
    check("drop_send_cmp2", cmp_en, 0);

    // done handshake, dropped request in DONE, then enable drop
    request(4'd7, 0, 1, 16'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("done_hold", resp_end, 1);
    end
    rxmsg = 4'd3; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0; rxmsg = '0;
    tick();
    check("done_drop_cmp", cmp_en, 0);
    check("done_drop_valid", valid, 0);
    check("done_drop_end", resp_end, 1);
    en = 1'b0;
    tick();
    model_clear_all();
    check("disable_end", resp_end, 0);
    check("disable_valid", valid, 0);
    check("disable_tx", tx, 0);
    check("disable_result", result, 0);
    en = 1'b1;
    tick();

    // Reset in SEND_RESP: once with compare enabled, once with a result held
    request(4'd3, 0, 0, 16'h0);
    for (int j = 0; j < 4; j++) strobe(16'hFFFF);
    reset_mid_send();
    request(4'd3, 0, 0, 16'h0);
    for (int j = 0; j < 10; j++) strobe(16'h00FF);
    request(4'd5, 0, 0, 16'h0);
    check("pre_rst_result", result, 16'h00FF);
    reset_mid_send();

    // Randomized phases against the model
    for (int it = 0; it < 25; it++) begin : rnd_iter
      logic [15:0] base;
      int          n;
      base = 16'($urandom);
      request(4'd3, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 16'($urandom));
      n = int'($urandom_range(0, 24));
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 5))
          0: begin
            match = 16'($urandom);
            tick();
            match = '0;
          end
          1: begin
            rxmsg     = ign[$urandom_range(0, 7)];
            msg_valid = 1'b1;
            strobe(base | (16'($urandom) & 16'($urandom)));
            msg_valid = 1'b0;
            rxmsg     = '0;
          end
          default: strobe(base | (16'($urandom) & 16'($urandom)));
        endcase
      end
      if ($urandom_range(0, 3) == 0) request(4'd1, int'($urandom_range(0, 2)), 0, 16'($urandom));
      request(4'd5, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 16'($urandom));
    end

    // Long wait in WAIT_REQ: no timeout without the feature
    repeat (40) tick();
    check("long_wait_err", err, 0);
    check("long_wait_valid", valid, 0);
    request(4'd1, 0, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
